// File: rtl/eth_tx_frame_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// eth_tx_frame_arbiter_pkg
// Shared helpers for the MAC transmit arbiter slice.
//   clog2_min1 : ceiling log2 of a positive value, never less than 1, so that
//                index and counter vectors always have at least one bit.
// ----------------------------------------------------------------------------
package eth_tx_frame_arbiter_pkg;

    function automatic int clog2_min1(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/eth_rr_select.sv
// ----------------------------------------------------------------------------
// eth_rr_select
// Combinational round-robin picker. Returns the first requesting port strictly
// after last_idx, wrapping from PORTS-1 back to 0.
// Ports:
//   req          in   PORTS   request vector
//   last_idx     in   IDX_W   index granted most recently
//   grant_onehot out  PORTS   one-hot selected port (all zero if no request)
//   grant_idx    out  IDX_W   index of selected port (0 if no request)
// ----------------------------------------------------------------------------
module eth_rr_select
    import eth_tx_frame_arbiter_pkg::*;
#(
    parameter  int PORTS = 4,
    localparam int IDX_W = clog2_min1(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [PORTS-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [2*PORTS-1:0] dbl_req;
    logic [2*PORTS-1:0] above_mask;
    logic [2*PORTS-1:0] masked_req;
    logic               found;

    // The request vector is duplicated so that masking off everything at or
    // below last_idx still leaves the wrapped-around ports in the upper copy;
    // a plain lowest-bit search over the masked vector then yields round-robin
    // order without any modular comparison.
    always_comb begin
        dbl_req      = {req, req};
        above_mask   = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        for (int i = 0; i < 2*PORTS; i++) begin
            above_mask[i] = (i > int'(last_idx));
        end
        masked_req = dbl_req & above_mask;
        for (int i = 0; i < 2*PORTS; i++) begin
            if (!found && masked_req[i]) begin
                found                    = 1'b1;
                grant_idx                = IDX_W'(i % PORTS);
                grant_onehot[i % PORTS]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// ----------------------------------------------------------------------------
// eth_tx_frame_arbiter
// Frame-level round-robin arbiter feeding the 1G MAC transmit AXI-stream.
// A grant is held for a whole frame so frames never interleave. Frames that
// reach MAX_FRAME_LEN beats without tlast are cut short on the output (forced
// tlast + tuser) and the remainder of the input frame is swallowed.
// Ports:
//   clk, rst_n         tx clock, synchronous active-low reset
//   s_axis_*           PORTS input streams, port i data at [8*i+7:8*i]
//   m_axis_*           single 8-bit stream towards the MAC
//   port_en            per-port arbitration enable (static configuration)
//   grant_valid        a port owns the output (transferring or dropping)
//   grant_idx          owning port index, holds its value while idle
//   frame_done         one-cycle pulse after a frame ends on the output
//   frame_oversize     one-cycle pulse after a frame is truncated
// ----------------------------------------------------------------------------
module eth_tx_frame_arbiter
    import eth_tx_frame_arbiter_pkg::*;
#(
    parameter  int PORTS         = 4,
    parameter  int MAX_FRAME_LEN = 1518,
    localparam int IDX_W         = clog2_min1(PORTS),
    localparam int CNT_W         = clog2_min1(MAX_FRAME_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PORTS*8-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]     s_axis_tvalid,
    output logic [PORTS-1:0]     s_axis_tready,
    input  logic [PORTS-1:0]     s_axis_tlast,
    input  logic [PORTS-1:0]     s_axis_tuser,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic [PORTS-1:0]     port_en,
    output logic                 grant_valid,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 frame_done,
    output logic                 frame_oversize
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DROP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   beat_cnt;
    logic [PORTS-1:0]   grant_oh;

    logic [PORTS-1:0]   req;
    logic [PORTS-1:0]   sel_oh;
    logic [IDX_W-1:0]   sel_idx;

    logic [7:0]         g_data;
    logic               g_valid;
    logic               g_last;
    logic               g_user;
    logic               at_limit;
    logic               truncate;
    logic               in_xfer;
    logic               in_drop;

    assign req = s_axis_tvalid & port_en;

    eth_rr_select #(
        .PORTS (PORTS)
    ) u_select (
        .req          (req),
        .last_idx     (last_grant),
        .grant_onehot (sel_oh),
        .grant_idx    (sel_idx)
    );

    assign g_data   = s_axis_tdata[{grant_idx, 3'b000} +: 8];
    assign g_valid  = s_axis_tvalid[grant_idx];
    assign g_last   = s_axis_tlast[grant_idx];
    assign g_user   = s_axis_tuser[grant_idx];
    assign in_xfer  = (state == ST_XFER);
    assign in_drop  = (state == ST_DROP);

    // The last beat the MAC may see; if the input has not ended its frame
    // here, this beat is turned into a bad end-of-frame.
    assign at_limit = (beat_cnt == CNT_W'(MAX_FRAME_LEN - 1));
    assign truncate = at_limit & ~g_last;

    // Zero-latency pass-through of the owning port. While dropping, the owner
    // is always ready so the rest of an oversize frame drains at full rate.
    always_comb begin
        m_axis_tdata  = in_xfer ? g_data : 8'h00;
        m_axis_tvalid = in_xfer & g_valid;
        m_axis_tlast  = in_xfer & (g_last | truncate);
        m_axis_tuser  = in_xfer & (g_user | truncate);
        s_axis_tready = '0;
        if (in_xfer) begin
            s_axis_tready = grant_oh & {PORTS{m_axis_tready}};
        end else if (in_drop) begin
            s_axis_tready = grant_oh;
        end
    end

    // Arbitration takes the single IDLE cycle between frames; once a port is
    // chosen it keeps the output until its tlast handshake (or truncation
    // followed by the drop of its remaining beats).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            last_grant     <= IDX_W'(PORTS - 1);
            beat_cnt       <= '0;
            grant_oh       <= '0;
            grant_idx      <= '0;
            grant_valid    <= 1'b0;
            frame_done     <= 1'b0;
            frame_oversize <= 1'b0;
        end else begin
            frame_done     <= 1'b0;
            frame_oversize <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant_idx   <= sel_idx;
                        grant_oh    <= sel_oh;
                        last_grant  <= sel_idx;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (g_valid && m_axis_tready) begin
                        if (g_last) begin
                            frame_done  <= 1'b1;
                            beat_cnt    <= '0;
                            grant_valid <= 1'b0;
                            state       <= ST_IDLE;
                        end else if (at_limit) begin
                            frame_done     <= 1'b1;
                            frame_oversize <= 1'b1;
                            beat_cnt       <= '0;
                            state          <= ST_DROP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (g_valid && g_last) begin
                        grant_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
